// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer: iterative restoring divider for DIV/DIVU beside the EX ALU.
// Stalls the front of the pipeline while iterating, then presents
// {remainder, quotient} with one-cycle HI/LO write strobes.
module hilo_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               StartIn,
    input  logic               SignedIn,
    input  logic [WIDTH-1:0]   DividendIn,
    input  logic [WIDTH-1:0]   DivisorIn,
    input  logic               FlushIn,
    output logic               BusyOut,
    output logic               StallOut,
    output logic               DoneOut,
    output logic               DivZeroOut,
    output logic               HiWriteOut,
    output logic               LoWriteOut,
    output logic [2*WIDTH-1:0] ALU64ResultOut
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    // Control state (reset)
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_divzero;
    logic [2*WIDTH-1:0] r_result;

    // Datapath state (no reset; always written before it is read)
    logic                    r_signed;
    logic signed [WIDTH-1:0] r_dvd;
    logic signed [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]          r_mdvs;
    logic [WIDTH-1:0]        r_rem;
    logic [WIDTH-1:0]        r_quo;
    logic                    r_qneg;
    logic                    r_rneg;
    logic                    r_dz;

    logic                    w_accept;
    logic [WIDTH:0]          w_shift;
    logic                    w_ge;
    logic                    w_last;
    logic [WIDTH-1:0]        w_q_fix;
    logic [WIDTH-1:0]        w_r_fix;

    // Magnitude in WIDTH+1 bits so the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH:0] f_mag(input logic [WIDTH-1:0] v, input logic take);
        if (take && v[WIDTH-1])
            f_mag = -{1'b1, v};
        else
            f_mag = {1'b0, v};
    endfunction

    // Conditional two's-complement negation used for the final sign fix-up.
    function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic neg);
        f_neg_if = neg ? -v : v;
    endfunction

    assign w_accept = StartIn && !FlushIn && (r_state == S_IDLE || r_state == S_DONE);
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_shift >= r_mdvs);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_q_fix  = r_dz ? '1 : f_neg_if(r_quo, r_qneg);
    assign w_r_fix  = r_dz ? r_dvd : f_neg_if(r_rem, r_rneg);

    // Sequencer FSM with registered busy/done/divide-by-zero flags and result register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            if (FlushIn) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (StartIn) begin
                            r_state <= S_PREP;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_PREP: begin
                        r_state <= S_ITER;
                        r_cnt   <= '0;
                    end
                    S_ITER: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last)
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_state   <= S_DONE;
                        r_result  <= {w_r_fix, w_q_fix};
                        r_done    <= 1'b1;
                        r_divzero <= r_dz;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Operand capture, magnitude/sign preparation and one restoring step per ITER cycle.
    always_ff @(posedge Clk) begin
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    r_signed <= SignedIn;
                    r_dvd    <= DividendIn;
                    r_dvs    <= DivisorIn;
                end
            end
            S_PREP: begin
                r_quo  <= WIDTH'(f_mag(r_dvd, r_signed));
                r_mdvs <= f_mag(r_dvs, r_signed);
                r_rem  <= '0;
                r_qneg <= r_signed && (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
                r_rneg <= r_signed && r_dvd[WIDTH-1];
                r_dz   <= (r_dvs == '0);
            end
            S_ITER: begin
                r_rem <= w_ge ? WIDTH'(w_shift - r_mdvs) : WIDTH'(w_shift);
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
            end
            default: ;
        endcase
    end

    assign BusyOut        = r_busy;
    assign StallOut       = (r_state == S_IDLE && StartIn && !FlushIn) ||
                            r_state == S_PREP || r_state == S_ITER || r_state == S_FIX;
    assign DoneOut        = r_done;
    assign HiWriteOut     = r_done;
    assign LoWriteOut     = r_done;
    assign DivZeroOut     = r_divzero;
    assign ALU64ResultOut = r_result;

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Bench for hilo_div_sequencer: timing/arithmetic reference model plus directed
// and randomized divides, flushes and asynchronous resets.
module tb_hilo_div_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          StartIn = 1'b0;
    logic          SignedIn = 1'b0;
    logic [W-1:0]  DividendIn = '0;
    logic [W-1:0]  DivisorIn = '0;
    logic          FlushIn = 1'b0;
    logic          BusyOut, StallOut, DoneOut, DivZeroOut, HiWriteOut, LoWriteOut;
    logic [2*W-1:0] ALU64ResultOut;

    int total = 0;
    int bad   = 0;

    hilo_div_sequencer #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .StartIn(StartIn), .SignedIn(SignedIn),
        .DividendIn(DividendIn), .DivisorIn(DivisorIn), .FlushIn(FlushIn),
        .BusyOut(BusyOut), .StallOut(StallOut), .DoneOut(DoneOut),
        .DivZeroOut(DivZeroOut), .HiWriteOut(HiWriteOut), .LoWriteOut(LoWriteOut),
        .ALU64ResultOut(ALU64ResultOut)
    );

    always #5 Clk = ~Clk;

    // Architectural result of DIV/DIVU: {remainder, quotient}
    function automatic logic [63:0] exp_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_age = cycles since the accepting edge (0 = nothing in flight).
    // Ages 1..LAT-1 stall; age LAT is the result cycle.
    int          m_age = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_res = '0;
    logic        m_pend_dz = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_age     = 0;
            m_res     = '0;
            m_pend_dz = 1'b0;
        end else begin
            if (FlushIn) begin
                m_age = 0;
            end else if ((m_age == 0 || m_age == LAT) && StartIn) begin
                m_pend    = exp_div(SignedIn, DividendIn, DivisorIn);
                m_pend_dz = (DivisorIn == 0);
                m_age     = 1;
            end else if (m_age == LAT) begin
                m_age = 0;
            end else if (m_age != 0) begin
                m_age++;
            end
            if (m_age == LAT) m_res = m_pend;
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge Clk) begin
        chk1("busy", BusyOut, m_age != 0);
        chk1("stall", StallOut, (m_age >= 1 && m_age <= LAT - 1) || (m_age == 0 && StartIn && !FlushIn));
        chk1("done", DoneOut, m_age == LAT);
        chk1("hiwrite", HiWriteOut, m_age == LAT);
        chk1("lowrite", LoWriteOut, m_age == LAT);
        chk1("divzero", DivZeroOut, m_age == LAT && m_pend_dz);
        chk64("result", ALU64ResultOut, m_res);
    end

    // Called at #1 after an edge; presents the request for one cycle.
    task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        StartIn = 1'b1; SignedIn = s; DividendIn = a; DivisorIn = b;
        @(posedge Clk); #1;
        StartIn = 1'b0;
    endtask

    // Returns at #1 inside the DoneOut cycle; k = cycles after the start edge.
    task automatic wait_done(output int k);
        k = 1;
        while (!DoneOut && k < 100) begin
            @(posedge Clk); #1;
            k++;
        end
        if (!DoneOut) begin
            total++; bad++;
            $display("FAIL done_timeout: got no DoneOut expected one within 100 cycles at %0t", $time);
        end
    endtask

    task automatic run_one(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input logic dz);
        int k;
        do_start(s, a, b);
        wait_done(k);
        chk64({nm, "_latency"}, 64'(k), 64'(LAT));
        chk64({nm, "_result"}, ALU64ResultOut, exp);
        chk1({nm, "_dz"}, DivZeroOut, dz);
        @(posedge Clk); #1;
        chk1({nm, "_done_drop"}, DoneOut, 1'b0);
    endtask

    initial begin
        int k, seen, c, fl;
        logic s, fin;
        logic [31:0] a, b;
        logic [63:0] e;

        // Pin the reference arithmetic with hand-computed values
        chk64("model_100_7", exp_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        chk64("model_m7_2", exp_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk64("model_ovf", exp_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk1("rst_busy", BusyOut, 1'b0);
        chk1("rst_stall", StallOut, 1'b0);
        chk1("rst_done", DoneOut, 1'b0);
        chk64("rst_result", ALU64ResultOut, 64'h0);
        #2 Rst_n = 1'b1;
        @(posedge Clk); #1;

        // DIVU 100/7 with stall check in the request cycle
        StartIn = 1'b1; SignedIn = 1'b0; DividendIn = 32'd100; DivisorIn = 32'd7;
        #1 chk1("stall_cycle0", StallOut, 1'b1);
        @(posedge Clk); #1;
        StartIn = 1'b0;
        wait_done(k);
        chk64("divu100_latency", 64'(k), 64'(LAT));
        chk1("divu100_stall_done", StallOut, 1'b0);
        chk64("divu100_result", ALU64ResultOut, 64'h00000002_0000000E);
        @(posedge Clk); #1;

        run_one("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_one("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
        run_one("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        run_one("divu_z", 1'b0, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF, 1'b1);

        // Flush during ITER cycle 10 (cycle 12 after the start edge)
        do_start(1'b0, 32'd1000, 32'd3);
        repeat (11) begin @(posedge Clk); #1; end
        FlushIn = 1'b1;
        @(posedge Clk); #1;
        FlushIn = 1'b0;
        chk1("flush_busy", BusyOut, 1'b0);
        chk64("flush_hold", ALU64ResultOut, 64'h00001234_FFFFFFFF);
        seen = 0;
        repeat (40) begin @(posedge Clk); #1; if (DoneOut) seen++; end
        chk64("flush_no_done", 64'(seen), 64'd0);
        run_one("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

        // Flush beats a simultaneous start in IDLE
        StartIn = 1'b1; FlushIn = 1'b1; DividendIn = 32'd5; DivisorIn = 32'd1;
        #1 chk1("flushprio_stall", StallOut, 1'b0);
        @(posedge Clk); #1;
        StartIn = 1'b0; FlushIn = 1'b0;
        chk1("flushprio_busy", BusyOut, 1'b0);

        // Asynchronous reset mid-ITER
        do_start(1'b0, 32'hDEADBEEF, 32'h13);
        repeat (10) @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        chk1("arst_busy", BusyOut, 1'b0);
        chk1("arst_stall", StallOut, 1'b0);
        chk1("arst_done", DoneOut, 1'b0);
        chk1("arst_hiwrite", HiWriteOut, 1'b0);
        chk64("arst_result", ALU64ResultOut, 64'h0);
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        seen = 0;
        repeat (45) begin @(posedge Clk); #1; if (DoneOut || HiWriteOut) seen++; end
        chk64("arst_no_strobe", 64'(seen), 64'd0);

        // Back-to-back: second start presented in the DONE cycle
        do_start(1'b0, 32'd1000, 32'd10);
        wait_done(k);
        chk64("b2b_first", ALU64ResultOut, 64'h00000000_00000064);
        do_start(1'b0, 32'd50, 32'd5);
        chk64("b2b_first_held", ALU64ResultOut, 64'h00000000_00000064);
        wait_done(k);
        chk64("b2b_latency", 64'(k), 64'(LAT));
        chk64("b2b_second", ALU64ResultOut, 64'h00000000_0000000A);
        @(posedge Clk); #1;

        // Randomized divides with occasional flushes and back-to-back starts
        for (int it = 0; it < 150; it++) begin
            s = 1'(($urandom_range(0, 1)));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
                default: b = $urandom;
            endcase
            e  = exp_div(s, a, b);
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0;
            do_start(s, a, b);
            c = 1; fin = 1'b0;
            while (!fin) begin
                if (fl != 0 && c == fl) begin
                    FlushIn = 1'b1;
                    @(posedge Clk); #1;
                    FlushIn = 1'b0;
                    fin = 1'b1;
                end else if (DoneOut) begin
                    chk64("rand_result", ALU64ResultOut, e);
                    chk64("rand_latency", 64'(c), 64'(LAT));
                    fin = 1'b1;
                    if ($urandom_range(0, 1) == 0) begin @(posedge Clk); #1; end
                end else if (c >= LAT + 5) begin
                    total++; bad++;
                    $display("FAIL rand_timeout: got no DoneOut expected one at cycle %0d", LAT);
                    fin = 1'b1;
                end else begin
                    @(posedge Clk); #1;
                    c++;
                end
            end
        end

        repeat (3) @(posedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_div_sequencer.md
# hilo_div_sequencer

Multi-cycle iterative divider and HI/LO write sequencer for DIV/DIVU, sitting beside the EX-stage ALU. It takes a divide request from EX, stalls the front of the pipeline for the iteration period, and presents a 64-bit {remainder, quotient} result with HI/LO write strobes. These outputs are muxed into the EX/MEM pipeline register's ALU64Result and HiWrite/LoWrite inputs. Pipeline stages downstream of EX keep draining while the divider runs, because it inserts bubbles rather than freezing EX/MEM.

## Interface
Parameters:
- WIDTH, 32, operand width; must be ≥ 2.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  reset, asynchronous, active-low.
- StartIn  in  1  divide request from EX, valid for one cycle.
- SignedIn  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with StartIn.
- DividendIn  in  WIDTH  rs operand; sampled with StartIn.
- DivisorIn  in  WIDTH  rt operand; sampled with StartIn.
- FlushIn  in  1  abort the in-flight divide (branch/exception flush).
- BusyOut  out  1  state ≠ IDLE.
- StallOut  out  1  holds PC, IF/ID and ID/EX, and forces a bubble into EX/MEM.
- DoneOut  out  1  one-cycle result-valid pulse.
- DivZeroOut  out  1  pulses with DoneOut when the divisor was 0.
- HiWriteOut  out  1  equals DoneOut.
- LoWriteOut  out  1  equals DoneOut.
- ALU64ResultOut  out  2*WIDTH  {remainder, quotient}: HI = [2W-1:W], LO = [W-1:0].

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE. All state, outputs and the iteration counter are registered.
- IDLE: StartIn=1 with FlushIn=0 captures operands and SignedIn, then moves to PREP.
- PREP:
  - Forms the magnitudes |dividend| and |divisor|. Magnitudes are taken only when SignedIn=1; otherwise the raw values are used.
  - Records qneg = sign(dividend) XOR sign(divisor) and rneg = sign(dividend).
  - Records dz = (divisor == 0).
  - Clears the counter and partial remainder, then moves to ITER.
- ITER:
  - One restoring-division step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor magnitude: rem -= divisor magnitude and the quotient LSB = 1.
  - The counter increments from 0 to WIDTH-1. When the counter reaches WIDTH-1, move to FIX.
  - Arithmetic is WIDTH+1 bits wide so that |0x80000000| = 2^31 is handled correctly.
- FIX:
  - Quotient is negated if qneg; remainder is negated if rneg.
  - If dz: quotient is forced to all-ones and remainder to the original dividend.
  - The result is written to the ALU64ResultOut register; the state moves to DONE.
- DONE:
  - DoneOut, HiWriteOut and LoWriteOut are 1; DivZeroOut is 1 when dz.
  - Next state is IDLE, or PREP if StartIn=1 this cycle (back-to-back divides are accepted).
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives Q = 0x80000000, R = 0. This falls out of the datapath with no special case.
- StallOut = (IDLE & StartIn & ~FlushIn) | PREP | ITER | FIX. It is 0 in DONE, so the pipeline releases while the result enters EX/MEM.
- StartIn while in PREP, ITER or FIX is ignored; it cannot occur while the pipeline is stalled.
- FlushIn in any state:
  - Next state is IDLE.
  - No DoneOut or write strobes are produced.
  - ALU64ResultOut is unchanged.
  - FlushIn has priority over StartIn in the same cycle.
- ALU64ResultOut holds the last completed result until the next FIX.

## Timing
- Reset (Rst_n=0, asynchronous): state = IDLE, counter = 0.
  - BusyOut, StallOut (registered part), DoneOut, DivZeroOut, HiWriteOut, LoWriteOut = 0.
  - ALU64ResultOut = 0.
  - Reset in any state, including mid-ITER, discards the operation with no strobes.
- Latency: when StartIn is sampled at edge E0, DoneOut is high in the cycle after edge E0+WIDTH+2. That is WIDTH+3 cycles: 1 PREP, WIDTH ITER, 1 FIX, then DONE (35 cycles for WIDTH=32).
- BusyOut is high from the cycle after E0 through the DONE cycle inclusive.
- ALU64ResultOut becomes valid in the DONE cycle, the same cycle as DoneOut.
- Throughput: one divide per WIDTH+3 cycles; the next start may be presented in the DONE cycle.

## Test plan
- DIVU 100 / 7 → Q = 14, R = 2, ALU64ResultOut = 0x00000002_0000000E. DoneOut pulses exactly 35 cycles after start; StallOut is high for cycles 0–34 and low in DONE.
- DIV 0xFFFFFFF9 (-7) / 2 → Q = 0xFFFFFFFD, R = 0xFFFFFFFF. Also DIV 7 / -2 → Q = 0xFFFFFFFD, R = 1.
- DIV 0x80000000 / 0xFFFFFFFF → Q = 0x80000000, R = 0, DivZeroOut = 0. DIVU 0x1234 / 0 → Q = 0xFFFFFFFF, R = 0x1234, DivZeroOut = 1 for one cycle.
- FlushIn at ITER cycle 10 → IDLE next edge, BusyOut = 0, no DoneOut/HiWriteOut/LoWriteOut, and ALU64ResultOut keeps its prior value. A new DIVU 9 / 3 → Q = 3, R = 0 then completes normally.
- Rst_n pulled low mid-ITER (asynchronously, between edges) → all outputs are 0 immediately. After release, no strobe appears without a new start.
- Back-to-back: StartIn (DIVU 50 / 5) asserted in the DONE cycle of a prior divide → the second DoneOut follows 35 cycles later with Q = 10, R = 0, and the first result stays visible until the second FIX.
